multdiv_sequencer: RTL and testbench
====================================

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 64, WAIT-state cycle limit; used only with MULTDIV_TIMEOUT_EN.
REQ-003 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports mult_signal, div_signal  in  1 each  decoded multiply/divide request from the instruction controller.
REQ-006 SHALL have ports data_operandA, data_operandB  in  DATA_W each  register-file read values; rd_in  in  5  destination register.
REQ-007 SHALL have ports md_ctrl_MULT, md_ctrl_DIV  out  1 each  one-cycle start pulses to the multdiv unit.
REQ-008 SHALL have ports md_operandA, md_operandB  out  DATA_W each  latched operands.
REQ-009 SHALL have ports md_result  in  DATA_W, md_exception  in  1, md_resultRDY  in  1  multdiv unit response.
REQ-010 SHALL have ports stall  out  1  pipeline freeze; busy  out  1  state != IDLE.
REQ-011 SHALL have ports wb_en  out  1, wb_rd  out  5, wb_data  out  DATA_W  regfile write port.

Function
REQ-012 SHALL implement FSM states IDLE, START, WAIT, WB.
REQ-013 In IDLE, when mult_signal or div_signal is 1, SHALL latch operands, rd_in and op type, then go to START; if both are 1, SHALL select multiply.
REQ-014 In START, SHALL assert exactly one of md_ctrl_MULT or md_ctrl_DIV for one cycle, then go to WAIT.
REQ-015 In WAIT, SHALL sample md_resultRDY. When it is 1, SHALL latch md_result and md_exception, then go to WB.
REQ-016 md_resultRDY in IDLE, START or WB SHALL be ignored.
REQ-017 In WB, SHALL hold wb_en=1 for one cycle, then go to IDLE.
REQ-018 WB data without exception: wb_rd = latched rd, wb_data = latched result.
REQ-019 wb_en SHALL be 0 in WB when latched rd is 0 and there is no exception.
REQ-020 WB data with exception: wb_rd = 30, wb_data = 4 for multiply or 5 for divide, zero-extended to DATA_W.
REQ-021 stall SHALL be combinational: (IDLE & (mult_signal|div_signal)) | START | WAIT. It SHALL be 0 in WB.
REQ-022 mult_signal/div_signal outside IDLE SHALL be ignored; there is no queueing.
REQ-023 Minimum latency, request to wb_en: 3 cycles (START, WAIT with RDY set, WB).
REQ-024 md_operandA/B SHALL hold their latched values from START until the next accepted request.

Reset
REQ-025 Reset low SHALL force IDLE immediately. All outputs SHALL go to 0 (stall=0, busy=0, wb_en=0, md_ctrl_*=0), and all latches SHALL clear.
REQ-026 Reset mid-operation SHALL abandon the operation: no writeback, no start pulse after release.

Configuration
REQ-027 Macro MULTDIV_TIMEOUT_EN SHALL control the WAIT-state timeout.
- When defined: a counter SHALL clear on START and increment each WAIT cycle.
- When the count reaches TIMEOUT_CYCLES with md_resultRDY still 0, the FSM SHALL go to WB with exception forced to 1.
- If md_resultRDY=1 on the limit cycle, the real result SHALL win.
REQ-028 When MULTDIV_TIMEOUT_EN is undefined, SHALL generate no counter logic. WAIT SHALL persist until md_resultRDY.

Structure
REQ-029 Package multdiv_seq_pkg SHALL hold: the FSM state enum, RSTATUS_REG=30, EXC_MULT=4, EXC_DIV=5.
REQ-030 The timeout counter SHALL be sub-module cycle_counter, with clear, enable, count and limit-reached outputs. It SHALL be instantiated only under MULTDIV_TIMEOUT_EN.

Verification
REQ-031 mult_signal=1, A=6, B=7, rd=3; RDY after 5 WAIT cycles.
- Required: one md_ctrl_MULT pulse, stall high until WB, then wb_en=1, wb_rd=3, wb_data=42.
REQ-032 div_signal=1, A=100, B=0, rd=4; md_exception=1 with RDY.
- Required: wb_rd=30, wb_data=5, no write to r4.
REQ-033 mult_signal and div_signal both 1.
- Required: only md_ctrl_MULT pulses; second request during WAIT is ignored.
REQ-034 rd=0 multiply, no exception.
- Required: wb_en stays 0, FSM returns to IDLE.
REQ-035 Reset asserted in WAIT.
- Required: next cycle stall=0, busy=0; a late md_resultRDY=1 causes no wb_en.
REQ-036 With MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8, RDY never set.
- Required: WB after 8 WAIT cycles with wb_rd=30, wb_data=4 (multiply).

Source files
------------

// File: rtl/multdiv_seq_pkg.sv
// Shared types and constants for the multiply/divide issue sequencer.
package multdiv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [2:0] EXC_MULT    = 3'd4;
  localparam logic [2:0] EXC_DIV     = 3'd5;

  // Status code written to the status register when an operation faults.
  function automatic logic [2:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/multdiv_sequencer_cycle_counter.sv
// Up-counter for bounding the result wait; limit_o flags the LIMIT-th enabled cycle.
module cycle_counter #(
  parameter int LIMIT = 64,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic [CW-1:0] count_o,
  output logic          limit_o
);

  logic [CW-1:0] count_q;

  // count_q holds the number of enabled cycles already completed, so the
  // current cycle is the LIMIT-th one when it equals LIMIT-1.
  assign limit_o = enable_i && (count_q == CW'(LIMIT - 1));
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !limit_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues one multiply/divide to the multdiv unit, waits for its result and writes it back.
// Define MULTDIV_TIMEOUT_EN to bound the wait to TIMEOUT_CYCLES and force an exception on expiry.
module multdiv_sequencer
  import multdiv_seq_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mult_signal,
  input  logic              div_signal,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic [4:0]        rd_in,
  output logic              md_ctrl_MULT,
  output logic              md_ctrl_DIV,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              stall,
  output logic              busy,
  output logic              wb_en,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  state_e              state_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [4:0]          rd_q;
  logic                is_div_q;
  logic                md_mult_q, md_div_q;
  logic                wb_en_q;
  logic [4:0]          wb_rd_q;
  logic [DATA_W-1:0]   wb_data_q;

  logic                req;
  logic                timeout_hit;
  logic                wait_done;
  logic                wb_exc;

  assign req = mult_signal | div_signal;

`ifdef MULTDIV_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] tmo_count;
  logic                                  unused_tmo_count;

  cycle_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (state_q == ST_START),
    .enable_i (state_q == ST_WAIT),
    .count_o  (tmo_count),
    .limit_o  (timeout_hit)
  );

  assign unused_tmo_count = ^tmo_count;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // A real result on the limit cycle takes priority over the timeout.
  assign wait_done = md_resultRDY | timeout_hit;
  assign wb_exc    = md_resultRDY ? md_exception : 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      md_mult_q <= 1'b0;
      md_div_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      md_mult_q <= 1'b0;
      md_div_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            opa_q     <= data_operandA;
            opb_q     <= data_operandB;
            rd_q      <= rd_in;
            is_div_q  <= ~mult_signal;
            md_mult_q <= mult_signal;
            md_div_q  <= ~mult_signal;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_done) begin
            // Writes to r0 are dropped unless a fault redirects them to the status register.
            wb_en_q   <= wb_exc | (rd_q != 5'd0);
            wb_rd_q   <= wb_exc ? RSTATUS_REG : rd_q;
            wb_data_q <= wb_exc ? DATA_W'(exc_code(is_div_q)) : md_result;
            state_q   <= ST_WB;
          end
        end
        ST_WB: begin
          wb_rd_q   <= '0;
          wb_data_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign md_ctrl_MULT = md_mult_q;
  assign md_ctrl_DIV  = md_div_q;
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign wb_en        = wb_en_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign stall        = reset & (((state_q == ST_IDLE) & req) |
                                 (state_q == ST_START) |
                                 (state_q == ST_WAIT));

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized self-checking bench for multdiv_sequencer against a transaction-level model.
module tb_multdiv_sequencer;

  localparam int W   = 32;
  localparam int TMO = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mult_signal = 1'b0, div_signal = 1'b0;
  logic [W-1:0]  data_operandA = '0, data_operandB = '0;
  logic [4:0]    rd_in = '0;
  logic          md_ctrl_MULT, md_ctrl_DIV;
  logic [W-1:0]  md_operandA, md_operandB;
  logic [W-1:0]  md_result = '0;
  logic          md_exception = 1'b0, md_resultRDY = 1'b0;
  logic          stall, busy, wb_en;
  logic [4:0]    wb_rd;
  logic [W-1:0]  wb_data;

  int checks   = 0;
  int failures = 0;

  logic [4:0] flags;
  assign flags = {stall, busy, wb_en, md_ctrl_MULT, md_ctrl_DIV};

  always #5 clock = ~clock;

  multdiv_sequencer #(
    .DATA_W         (W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mult_signal   (mult_signal),
    .div_signal    (div_signal),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .rd_in         (rd_in),
    .md_ctrl_MULT  (md_ctrl_MULT),
    .md_ctrl_DIV   (md_ctrl_DIV),
    .md_operandA   (md_operandA),
    .md_operandB   (md_operandB),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .md_resultRDY  (md_resultRDY),
    .stall         (stall),
    .busy          (busy),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic scramble();
    mult_signal   = 1'($urandom);
    div_signal    = 1'($urandom);
    data_operandA = $urandom;
    data_operandB = $urandom;
    rd_in         = 5'($urandom);
    md_resultRDY  = 1'($urandom);
    md_exception  = 1'($urandom);
    md_result     = $urandom;
  endtask

  // One full transaction. Entered and left just after a rising edge with the DUT idle.
  task automatic run_op(input string name, input bit m, input bit d,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd,
                        input int wait_n, input bit exc, input logic [W-1:0] res,
                        input bit never_rdy);
    bit           exp_div;
    bit           exp_exc;
    bit           exp_en;
    logic [4:0]   exp_rd;
    logic [W-1:0] exp_data;
    int           n_wait;
    exp_div  = d && !m;
    exp_exc  = exc || never_rdy;
    exp_en   = exp_exc || (rd != 5'd0);
    exp_rd   = exp_exc ? 5'd30 : rd;
    exp_data = exp_exc ? (exp_div ? 32'd5 : 32'd4) : res;
    n_wait   = never_rdy ? TMO : wait_n + 1;

    scramble();
    mult_signal = m; div_signal = d;
    data_operandA = a; data_operandB = b; rd_in = rd;
    @(negedge clock);
    checks++;
    if (flags !== 5'b10000) begin
      failures++;
      $display("FAIL %s accept: flags got=%b want=%b", name, flags, 5'b10000);
    end

    @(posedge clock); #1; scramble();
    @(negedge clock);
    checks++;
    if (flags !== {3'b110, !exp_div, exp_div}) begin
      failures++;
      $display("FAIL %s start_pulse: flags got=%b want=%b", name, flags, {3'b110, !exp_div, exp_div});
    end
    checks++;
    if ({md_operandA, md_operandB} !== {a, b}) begin
      failures++;
      $display("FAIL %s operands: got=%h/%h want=%h/%h", name, md_operandA, md_operandB, a, b);
    end

    for (int i = 0; i < n_wait; i++) begin
      @(posedge clock); #1; scramble();
      if (!never_rdy && i == wait_n) begin
        md_resultRDY = 1'b1; md_exception = exc; md_result = res;
      end else begin
        md_resultRDY = 1'b0;
      end
      @(negedge clock);
      checks++;
      if (flags !== 5'b11000) begin
        failures++;
        $display("FAIL %s wait_cycle%0d: flags got=%b want=%b", name, i, flags, 5'b11000);
      end
    end

    @(posedge clock); #1; scramble();
    @(negedge clock);
    checks++;
    if ({stall, busy, wb_en, md_ctrl_MULT, md_ctrl_DIV} !== {2'b01, exp_en, 2'b00}) begin
      failures++;
      $display("FAIL %s wb_flags: got=%b want=%b", name, flags, {2'b01, exp_en, 2'b00});
    end
    if (exp_en) begin
      checks++;
      if ({wb_rd, wb_data} !== {exp_rd, exp_data}) begin
        failures++;
        $display("FAIL %s wb_write: got rd=%0d data=%h want rd=%0d data=%h",
                 name, wb_rd, wb_data, exp_rd, exp_data);
      end
    end
    checks++;
    if ({md_operandA, md_operandB} !== {a, b}) begin
      failures++;
      $display("FAIL %s operand_hold: got=%h/%h want=%h/%h", name, md_operandA, md_operandB, a, b);
    end

    @(posedge clock); #1; scramble();
    mult_signal = 1'b0; div_signal = 1'b0;
    @(negedge clock);
    checks++;
    if (flags !== 5'b00000) begin
      failures++;
      $display("FAIL %s back_to_idle: flags got=%b want=%b", name, flags, 5'b00000);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    scramble();
    mult_signal = 1'b1;
    @(negedge clock);
    checks++;
    if (flags !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags: got=%b want=%b", flags, 5'b00000);
    end
    checks++;
    if ({md_operandA, md_operandB, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: got opA=%h opB=%h rd=%0d data=%h want all zero",
               md_operandA, md_operandB, wb_rd, wb_data);
    end
    @(posedge clock); #1;
    mult_signal = 1'b0; div_signal = 1'b0; md_resultRDY = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    run_op("mult_6x7", 1'b1, 1'b0, 32'd6, 32'd7, 5'd3, 5, 1'b0, 32'd42, 1'b0);
    run_op("div_by_zero", 1'b0, 1'b1, 32'd100, 32'd0, 5'd4, 2, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("rd_zero", 1'b1, 1'b0, 32'd9, 32'd9, 5'd0, 1, 1'b0, 32'd81, 1'b0);
    run_op("both_signals", 1'b1, 1'b1, 32'd12, 32'd3, 5'd17, 3, 1'b0, 32'd36, 1'b0);
    run_op("rdy_immediate", 1'b0, 1'b1, 32'd50, 32'd7, 5'd31, 0, 1'b0, 32'd7, 1'b0);
    run_op("rdy_limit_cycle", 1'b1, 1'b0, 32'd5, 32'd5, 5'd8, TMO - 1, 1'b0, 32'd25, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit m, d;
      logic [W-1:0] a, b, res;
      logic [4:0] rd;
      m = 1'($urandom);
      d = 1'($urandom);
      if (!m && !d) d = 1'b1;
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      res = (d && !m) ? ((b != 0) ? a / b : 32'hFFFF_FFFF) : a * b;
      run_op($sformatf("random%0d", n), m, d, a, b, rd, $urandom_range(0, TMO - 1),
             ($urandom_range(0, 3) == 0), res, 1'b0);
    end
  endtask

  task automatic test_reset_mid_op();
    mult_signal = 1'b1; data_operandA = 32'd11; data_operandB = 32'd13; rd_in = 5'd7;
    md_resultRDY = 1'b0;
    @(posedge clock); #1; mult_signal = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (flags !== 5'b11000) begin
      failures++;
      $display("FAIL reset_mid_pre: flags got=%b want=%b", flags, 5'b11000);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (flags !== 5'b00000) begin
      failures++;
      $display("FAIL reset_mid_async: flags got=%b want=%b", flags, 5'b00000);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    md_resultRDY = 1'b1; md_exception = 1'b0; md_result = 32'd143;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (flags !== 5'b00000) begin
        failures++;
        $display("FAIL reset_mid_late_rdy%0d: flags got=%b want=%b", i, flags, 5'b00000);
      end
      @(posedge clock); #1;
    end
    md_resultRDY = 1'b0;
  endtask

`ifdef MULTDIV_TIMEOUT_EN
  task automatic test_timeout();
    run_op("timeout_mult", 1'b1, 1'b0, 32'd3, 32'd4, 5'd9, 0, 1'b0, 32'd12, 1'b1);
    run_op("timeout_div", 1'b0, 1'b1, 32'd8, 32'd2, 5'd0, 0, 1'b0, 32'd4, 1'b1);
  endtask
`else
  task automatic test_long_wait();
    run_op("long_wait", 1'b1, 1'b0, 32'd1000, 32'd1000, 5'd21, 80, 1'b0, 32'd1000000, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_op();
`ifdef MULTDIV_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    run_op("after_all", 1'b1, 1'b0, 32'd2, 32'd21, 5'd1, 1, 1'b0, 32'd42, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
